irq_ctrl: RTL and testbench

External interrupt controller feeding the CPU's four external interrupt lines. Collects NSRC peripheral interrupt requests, latches their rising edges into a pending register, applies a software mask, and dispatches one source at a time. Each dispatch is a clean rising-edge pulse on the matching CPU external interrupt line. The block then waits for the CPU's `reti` acknowledge, or a timeout, before dispatching the next source. Sits between the peripherals and the CPU core. Software reads `cur_src` in the ISR to get the exact source, beyond the 1..4 line id.

---
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl -- external interrupt controller in front of the CPU's four
// external interrupt lines.
//
// Peripheral requests are rising-edge detected into a pending register.
// Pending bits are gated by a software mask, and the lowest eligible index
// is dispatched as a PULSE_LEN-cycle pulse on ext_int[sel % 4]. The
// controller then waits for a rising edge on reti, or a timeout, and holds
// ext_int low for one gap cycle before the next dispatch can start.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   src_irq         peripheral requests (rising-edge triggered)
//   mask_we/wdata   mask register write (1 = source enabled)
//   clr_we/wdata    write-1-to-clear pending; any write clears timeout_flag
//   reti            CPU return-from-interrupt (rising edge = acknowledge)
//   ext_int         CPU ext_int1..4 (bit n drives line n+1)
//   cur_src         index of the most recently dispatched source
//   pending, mask   register read-back
//   busy            high whenever the FSM is not idle
//   timeout_flag    sticky, set when an acknowledge timed out
module irq_ctrl #(
    parameter int NSRC        = 8,
    parameter int PULSE_LEN   = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            clr_we,
    input  logic [NSRC-1:0] clr_wdata,
    input  logic            reti,
    output logic [3:0]      ext_int,
    output logic [7:0]      cur_src,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask,
    output logic            busy,
    output logic            timeout_flag
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT_ACK,
        S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NSRC-1:0] src_prev;
    logic            reti_prev;
    logic [PW-1:0]   pulse_cnt;
    logic [TW-1:0]   ack_cnt;

    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] disp_bits;
    logic [3:0]      sel;
    logic            sel_found;
    logic            dispatch;
    logic            reti_rise;
    logic            ack_expire;

    assign eligible   = pending & mask;
    assign rise       = src_irq & ~src_prev;
    assign clr_bits   = clr_we ? clr_wdata : '0;
    assign reti_rise  = reti & ~reti_prev;
    assign ack_expire = (ack_cnt == TW'(ACK_TIMEOUT - 1));
    assign dispatch   = (state == S_IDLE) && (eligible != '0);
    assign disp_bits  = dispatch ? (NSRC'(1) << sel) : '0;

    // Lowest eligible index has priority.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (eligible[i] && !sel_found) begin
                sel       = 4'(i);
                sel_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (dispatch) state_nxt = S_PULSE;
            S_PULSE:    if (pulse_cnt == '0) state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (reti_rise || ack_expire) state_nxt = S_GAP;
            S_GAP:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Outputs: decoded from registered state and cur_src, so ext_int only
    // changes on clock edges and at most one line is ever high.
    always_comb begin
        busy    = (state != S_IDLE);
        ext_int = '0;
        if (state == S_PULSE) ext_int[cur_src[1:0]] = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            // src_prev tracks the live input during reset so that a request
            // already high at reset release is not seen as a new edge.
            src_prev     <= src_irq;
            reti_prev    <= 1'b0;
            pending      <= '0;
            mask         <= '0;
            cur_src      <= '0;
            timeout_flag <= 1'b0;
            pulse_cnt    <= '0;
            ack_cnt      <= '0;
        end else begin
            src_prev  <= src_irq;
            reti_prev <= reti;

            // New edges win over both clear sources on the same bit.
            pending <= (pending & ~clr_bits & ~disp_bits) | rise;

            if (mask_we) mask <= mask_wdata;

            if (state == S_WAIT_ACK && !reti_rise && ack_expire)
                timeout_flag <= 1'b1;
            else if (clr_we)
                timeout_flag <= 1'b0;

            if (dispatch) begin
                cur_src   <= 8'(sel);
                pulse_cnt <= PW'(PULSE_LEN - 1);
            end else if (state == S_PULSE && pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - 1'b1;
            end

            if (state != S_WAIT_ACK)
                ack_cnt <= '0;
            else if (ack_cnt != TW'(ACK_TIMEOUT))
                ack_cnt <= ack_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl -- directed bench for irq_ctrl with a cycle-level model.
// The model tracks each dispatch by its age in cycles rather than by FSM
// state; outputs are compared against it on every falling edge, and
// hand-computed literal checks pin the model at key points.
module tb_irq_ctrl;

    localparam int NSRC   = 8;
    localparam int PL     = 2;
    localparam int ACK_TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src_irq;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            clr_we;
    logic [NSRC-1:0] clr_wdata;
    logic            reti;
    logic [3:0]      ext_int;
    logic [7:0]      cur_src;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic            busy;
    logic            timeout_flag;

    irq_ctrl #(.NSRC(NSRC), .PULSE_LEN(PL), .ACK_TIMEOUT(ACK_TO)) dut (
        .clk(clk), .reset(reset), .src_irq(src_irq),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .clr_we(clr_we), .clr_wdata(clr_wdata), .reti(reti),
        .ext_int(ext_int), .cur_src(cur_src), .pending(pending),
        .mask(mask), .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age: 0 = no dispatch in flight; 1..PL = pulse cycles; above PL the
    // number of acknowledge-wait cycles so far is m_age - PL.
    logic [NSRC-1:0] m_pend, m_mask, m_prev, m_elig, m_rise, m_clr, m_dbits;
    logic            m_rprev;
    int              m_cur, m_age;
    bit              m_gap, m_flag, m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pend = '0; m_mask = '0; m_prev = src_irq; m_rprev = 1'b0;
            m_cur = 0; m_age = 0; m_gap = 1'b0; m_flag = 1'b0; m_valid = 1'b1;
        end else begin
            m_elig  = m_pend & m_mask;
            m_rise  = src_irq & ~m_prev;
            m_clr   = clr_we ? clr_wdata : '0;
            m_dbits = '0;
            if (clr_we) m_flag = 1'b0;
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (m_age == 0) begin
                if (m_elig != '0) begin
                    for (int k = NSRC - 1; k >= 0; k--)
                        if (m_elig[k]) m_cur = k;
                    m_dbits = NSRC'(1) << m_cur;
                    m_age   = 1;
                end
            end else if (m_age <= PL) begin
                m_age++;
            end else if (reti && !m_rprev) begin
                m_age = 0; m_gap = 1'b1;
            end else if (m_age - PL == ACK_TO) begin
                m_flag = 1'b1; m_age = 0; m_gap = 1'b1;
            end else begin
                m_age++;
            end
            m_pend  = (m_pend & ~m_clr & ~m_dbits) | m_rise;
            if (mask_we) m_mask = mask_wdata;
            m_prev  = src_irq;
            m_rprev = reti;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_ext_int", 32'(ext_int),
                (m_age >= 1 && m_age <= PL) ? 32'(1 << (m_cur % 4)) : 32'd0);
            chk("m_cur_src", 32'(cur_src), 32'(m_cur));
            chk("m_pending", 32'(pending), 32'(m_pend));
            chk("m_mask", 32'(mask), 32'(m_mask));
            chk("m_busy", 32'(busy), 32'(m_age != 0 || m_gap));
            chk("m_timeout_flag", 32'(timeout_flag), 32'(m_flag));
            chk("m_onehot", 32'($onehot0(ext_int)), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [NSRC-1:0] v);
        mask_we = 1'b1; mask_wdata = v;
        step(1);
        mask_we = 1'b0;
    endtask

    task automatic ack();
        reti = 1'b1;
        step(1);
        reti = 1'b0;
        step(1);
    endtask

    initial begin
        reset = 1'b1; src_irq = '0; mask_we = 1'b0; mask_wdata = '0;
        clr_we = 1'b0; clr_wdata = '0; reti = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);
        chk("reset_ext_int", 32'(ext_int), 32'd0);
        chk("reset_mask", 32'(mask), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Single source 5
        write_mask(8'hFF);
        src_irq[5] = 1'b1; step(1); src_irq = '0;
        chk("s5_pending_set", 32'(pending), 32'h20);
        chk("s5_no_int_yet", 32'(ext_int), 32'd0);
        step(1);
        chk("s5_ext_int", 32'(ext_int), 32'b0010);
        chk("s5_cur_src", 32'(cur_src), 32'd5);
        chk("s5_pending_clr", 32'(pending), 32'd0);
        step(1);
        chk("s5_ext_int_2nd", 32'(ext_int), 32'b0010);
        step(1);
        chk("s5_ext_int_low", 32'(ext_int), 32'd0);
        chk("s5_busy_wait", 32'(busy), 32'd1);
        step(2);
        ack();
        chk("s5_busy_after_ack", 32'(busy), 32'd0);

        // Priority: sources 6 and 1 together
        src_irq = 8'h42; step(1); src_irq = '0;
        step(1);
        chk("pri_first_int", 32'(ext_int), 32'b0010);
        chk("pri_first_src", 32'(cur_src), 32'd1);
        step(3);
        ack();
        step(1);
        chk("pri_second_int", 32'(ext_int), 32'b0100);
        chk("pri_second_src", 32'(cur_src), 32'd6);
        step(3);
        ack();

        // Masking
        write_mask(8'h00);
        src_irq[3] = 1'b1; step(1); src_irq = '0;
        chk("msk_pending", 32'(pending), 32'h08);
        step(2);
        chk("msk_no_int", 32'(ext_int), 32'd0);
        chk("msk_idle", 32'(busy), 32'd0);
        write_mask(8'h08);
        chk("msk_not_yet", 32'(ext_int), 32'd0);
        step(1);
        chk("msk_dispatch", 32'(ext_int), 32'b1000);
        chk("msk_cur_src", 32'(cur_src), 32'd3);
        step(3);
        ack();

        // Timeout on source 0
        write_mask(8'hFF);
        src_irq[0] = 1'b1; step(1); src_irq = '0;
        step(1);
        chk("to_ext_int", 32'(ext_int), 32'b0001);
        step(17);
        chk("to_flag_before", 32'(timeout_flag), 32'd0);
        chk("to_busy_before", 32'(busy), 32'd1);
        step(1);
        chk("to_flag_set", 32'(timeout_flag), 32'd1);
        step(1);
        chk("to_idle", 32'(busy), 32'd0);
        clr_we = 1'b1; clr_wdata = '0; step(1); clr_we = 1'b0;
        chk("to_flag_clr", 32'(timeout_flag), 32'd0);

        // reti held through the pulse is not an acknowledge
        src_irq[4] = 1'b1; step(1); src_irq = '0;
        step(1);
        chk("rp_ext_int", 32'(ext_int), 32'b0001);
        reti = 1'b1;
        step(4);
        chk("rp_still_busy", 32'(busy), 32'd1);
        reti = 1'b0; step(1);
        ack();
        chk("rp_idle", 32'(busy), 32'd0);

        // Clear vs set on the same bit
        write_mask(8'h00);
        src_irq[2] = 1'b1; clr_we = 1'b1; clr_wdata = 8'h04;
        step(1);
        src_irq = '0;
        chk("cs_set_wins", 32'(pending), 32'h04);
        step(1);
        clr_we = 1'b0; clr_wdata = '0;
        chk("cs_cleared", 32'(pending), 32'd0);

        // Reset during a pulse, request held high across reset
        write_mask(8'hFF);
        src_irq[7] = 1'b1; step(2);
        chk("rs_ext_int", 32'(ext_int), 32'b1000);
        reset = 1'b1; step(1);
        chk("rs_ext_int_0", 32'(ext_int), 32'd0);
        chk("rs_mask_0", 32'(mask), 32'd0);
        chk("rs_cur_src_0", 32'(cur_src), 32'd0);
        chk("rs_busy_0", 32'(busy), 32'd0);
        reset = 1'b0;
        write_mask(8'hFF);
        step(5);
        chk("rs_no_pending", 32'(pending), 32'd0);
        chk("rs_no_dispatch", 32'(busy), 32'd0);
        src_irq = '0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
